// File: rtl/line_buf4_if.sv
// Pixel-stream and tap bundle between the camera front end and line_buf4.
// The master drives the pixel stream; the slave (line_buf4) returns the registered taps.
interface line_buf4_if #(
   parameter int AW = 10
);
   logic          sof_in;
   logic [7:0]    pix_in;
   logic          pix_valid_in;
   logic [7:0]    line0_out;
   logic [7:0]    line1_out;
   logic [7:0]    line2_out;
   logic [7:0]    line3_out;
   logic [7:0]    cur_pix_out;
   logic [1:0]    sel_out;
   logic [AW-1:0] col_out;
   logic          taps_valid_out;

   modport master (
      output sof_in, pix_in, pix_valid_in,
      input  line0_out, line1_out, line2_out, line3_out,
      input  cur_pix_out, sel_out, col_out, taps_valid_out
   );

   modport slave (
      input  sof_in, pix_in, pix_valid_in,
      output line0_out, line1_out, line2_out, line3_out,
      output cur_pix_out, sel_out, col_out, taps_valid_out
   );
endinterface

// File: rtl/line_buf4.sv
// Four-bank round-robin line buffer; every accepted pixel reads all banks at its column.
// Optional macro BORDER_REPLICATE_EN: empty banks replicate the current pixel and taps are always valid.
module line_buf4 #(
   parameter int LINE_W = 640,
   parameter int AW     = 10
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   line_buf4_if.slave  bus
);

   logic [7:0]    r_mem [0:3][0:LINE_W-1];
   logic [AW-1:0] r_wcol;
   logic [1:0]    r_wbank;
   logic [1:0]    r_lines_done;

   logic [7:0]    r_line [0:3];
   logic [7:0]    r_cur_pix;
   logic [1:0]    r_sel;
   logic [AW-1:0] r_col;
   logic          r_taps_valid;

   logic [AW-1:0] w_addr;
   logic [1:0]    w_bank;
   logic [1:0]    w_ld;
   logic          w_last;
   logic          w_taps_valid;
   logic [7:0]    w_tap [0:3];

   // A start-of-frame pixel is steered to column 0 of bank 0 with no history.
   always_comb begin
      w_addr       = r_wcol;
      w_bank       = r_wbank;
      w_ld         = r_lines_done;
      w_taps_valid = 1'b0;
      if (bus.sof_in) begin
         w_addr = '0;
         w_bank = 2'd0;
         w_ld   = 2'd0;
      end else begin
         w_addr = r_wcol;
         w_bank = r_wbank;
         w_ld   = r_lines_done;
      end
      w_last = (w_addr == AW'(LINE_W - 1));
`ifdef BORDER_REPLICATE_EN
      w_taps_valid = 1'b1;
      for (int b = 0; b < 4; b++) begin
         // Banks holding no row of this frame mirror the incoming pixel.
         if ((2'(b) != w_bank) && (2'(b) >= w_ld)) begin
            w_tap[b] = bus.pix_in;
         end else begin
            w_tap[b] = r_mem[b][w_addr];
         end
      end
`else
      w_taps_valid = (w_ld == 2'd3);
      for (int b = 0; b < 4; b++) begin
         w_tap[b] = r_mem[b][w_addr];
      end
`endif
   end

   // Line RAM write port; contents survive reset.
   always_ff @(posedge clk_in) begin
      if (rst_n_in && bus.pix_valid_in) begin
         r_mem[w_bank][w_addr] <= bus.pix_in;
      end
   end

   // Write pointer, line history and registered tap outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_wcol       <= '0;
         r_wbank      <= 2'd0;
         r_lines_done <= 2'd0;
         for (int b = 0; b < 4; b++) begin
            r_line[b] <= 8'd0;
         end
         r_cur_pix    <= 8'd0;
         r_sel        <= 2'd0;
         r_col        <= '0;
         r_taps_valid <= 1'b0;
      end else if (bus.pix_valid_in) begin
         for (int b = 0; b < 4; b++) begin
            r_line[b] <= w_tap[b];
         end
         r_cur_pix    <= bus.pix_in;
         r_sel        <= w_bank;
         r_col        <= w_addr;
         r_taps_valid <= w_taps_valid;
         if (w_last) begin
            r_wcol       <= '0;
            r_wbank      <= w_bank + 2'd1;
            r_lines_done <= (w_ld == 2'd3) ? 2'd3 : (w_ld + 2'd1);
         end else begin
            r_wcol       <= w_addr + AW'(1);
            r_wbank      <= w_bank;
            r_lines_done <= w_ld;
         end
      end else begin
         r_taps_valid <= 1'b0;
         if (bus.sof_in) begin
            r_wcol       <= '0;
            r_wbank      <= 2'd0;
            r_lines_done <= 2'd0;
         end else begin
            r_wcol       <= r_wcol;
            r_wbank      <= r_wbank;
            r_lines_done <= r_lines_done;
         end
      end
   end

   assign bus.line0_out      = r_line[0];
   assign bus.line1_out      = r_line[1];
   assign bus.line2_out      = r_line[2];
   assign bus.line3_out      = r_line[3];
   assign bus.cur_pix_out    = r_cur_pix;
   assign bus.sel_out        = r_sel;
   assign bus.col_out        = r_col;
   assign bus.taps_valid_out = r_taps_valid;

endmodule

// File: tb/tb_line_buf4.sv
// Directed bench for line_buf4 with LINE_W=4, AW=2; pixel values follow base+16*row+col.
// Tap expectations are derived from the row index within the current frame.
module tb_line_buf4;
   localparam int LINE_W = 4;
   localparam int AW     = 2;

   logic clk;
   logic rst_n;
   int   n_vec  = 0;
   int   n_fail = 0;

   int   e_cur, e_sel, e_col, e_taps;
   int   e_line  [4];
   bit   e_known [4];

   line_buf4_if #(.AW(AW)) bus ();

   line_buf4 #(.LINE_W(LINE_W), .AW(AW)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] line_of(input int b);
      case (b)
         0:       line_of = bus.line0_out;
         1:       line_of = bus.line1_out;
         2:       line_of = bus.line2_out;
         default: line_of = bus.line3_out;
      endcase
   endfunction

   task automatic drive(input logic s, input logic v, input logic [7:0] p);
      bus.sof_in       = s;
      bus.pix_valid_in = v;
      bus.pix_in       = p;
      @(posedge clk);
      #1;
      bus.pix_valid_in = 1'b0;
      bus.sof_in       = 1'b0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".taps"}, {31'd0, bus.taps_valid_out}, e_taps);
      chk({tag, ".cur"},  {24'd0, bus.cur_pix_out}, e_cur);
      chk({tag, ".sel"},  {30'd0, bus.sel_out}, e_sel);
      chk({tag, ".col"},  {30'd0, bus.col_out}, e_col);
      for (int b = 0; b < 4; b++) begin
         if (e_known[b]) chk($sformatf("%s.line%0d", tag, b), {24'd0, line_of(b)}, e_line[b]);
      end
   endtask

   // One idle cycle: everything holds, taps drop.
   task automatic idle(input logic s, input string tag);
      drive(s, 1'b0, 8'hA5);
      e_taps = 0;
      chk_all(tag);
   endtask

   // One accepted pixel at frame row r, column c.
   task automatic px(input logic s, input int r, input int c, input int base, input bit gap);
      int d, rp;
      if (gap) idle(1'b0, "gap");
      drive(s, 1'b1, 8'(base + 16 * r + c));
      e_cur = (base + 16 * r + c) & 255;
      e_sel = r % 4;
      e_col = c;
`ifdef BORDER_REPLICATE_EN
      e_taps = 1;
`else
      e_taps = (r >= 3) ? 1 : 0;
`endif
      for (int b = 0; b < 4; b++) begin
         d = (r + 4 - b) % 4;
         if (d == 0) d = 4;
         rp = r - d;
         if (rp >= 0) begin
            e_line[b]  = (base + 16 * rp + c) & 255;
            e_known[b] = 1'b1;
         end else begin
`ifdef BORDER_REPLICATE_EN
            e_known[b] = (b != r % 4);
            e_line[b]  = e_cur;
`else
            e_known[b] = 1'b0;
`endif
         end
      end
      chk_all($sformatf("px r%0d c%0d", r, c));
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 8'h77);
      rst_n = 1'b1;
      e_cur = 0; e_sel = 0; e_col = 0; e_taps = 0;
      for (int b = 0; b < 4; b++) begin
         e_line[b]  = 0;
         e_known[b] = 1'b1;
      end
      chk_all(tag);
   endtask

   initial begin
      rst_n = 1'b1;
      bus.sof_in = 1'b0; bus.pix_valid_in = 1'b0; bus.pix_in = 8'd0;
      #2;
      do_reset("reset0");

      // Reset mid-line, then a fresh sof pixel lands at bank 0 col 0
      px(1'b1, 0, 0, 8'h10, 1'b0);
      px(1'b0, 0, 1, 8'h10, 1'b0);
      px(1'b0, 0, 2, 8'h10, 1'b0);
      do_reset("reset_mid");
      px(1'b1, 0, 0, 0, 1'b0);

      // Fill: rows 0..4, with fixed check at row 4 col 2
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < LINE_W; c++)
            px((r == 0 && c == 0), r, c, 0, 1'b0);
      // pixel stream re-run to stop at row4 col2 for constant checks
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < LINE_W; c++)
            if (r < 4 || c <= 2) begin
               px((r == 0 && c == 0), r, c, 0, 1'b0);
            end
      chk("r4c2.sel",   {30'd0, bus.sel_out},    32'd0);
      chk("r4c2.line0", {24'd0, bus.line0_out},  32'h02);
      chk("r4c2.line1", {24'd0, bus.line1_out},  32'h12);
      chk("r4c2.line2", {24'd0, bus.line2_out},  32'h22);
      chk("r4c2.line3", {24'd0, bus.line3_out},  32'h32);
      chk("r4c2.cur",   {24'd0, bus.cur_pix_out}, 32'h42);
      chk("r4c2.col",   {30'd0, bus.col_out},    32'd2);
      chk("r4c2.taps",  {31'd0, bus.taps_valid_out}, 32'd1);

      // Gaps: same stream with an idle cycle before every pixel
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < LINE_W; c++)
            px((r == 0 && c == 0), r, c, 0, 1'b1);

      // Wrap: nine lines, bank select cycles through 0..3
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < LINE_W; c++)
            px((r == 0 && c == 0), r, c, 0, 1'b0);

      // sof mid-line at row 2 col 2 starts a new frame
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < LINE_W; c++)
            if (r < 2 || c < 2) px((r == 0 && c == 0), r, c, 0, 1'b0);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < LINE_W; c++)
            px((r == 0 && c == 0), r, c, 8'h80, 1'b0);
      chk("sof_mid.r4c3.line0", {24'd0, bus.line0_out}, 32'h83);

      // sof without a valid pixel rewinds the pointer; next pixel is col 0 bank 0
      px(1'b1, 0, 0, 0, 1'b0);
      px(1'b0, 0, 1, 0, 1'b0);
      idle(1'b1, "sof_idle");
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < LINE_W; c++)
            px(1'b0, r, c, 8'h40, 1'b0);

`ifdef BORDER_REPLICATE_EN
      // Replication: row 1 col 1
      px(1'b1, 0, 0, 0, 1'b0);
      px(1'b0, 0, 1, 0, 1'b0);
      px(1'b0, 0, 2, 0, 1'b0);
      px(1'b0, 0, 3, 0, 1'b0);
      px(1'b0, 1, 0, 0, 1'b0);
      px(1'b0, 1, 1, 0, 1'b0);
      chk("brd.taps",  {31'd0, bus.taps_valid_out}, 32'd1);
      chk("brd.line0", {24'd0, bus.line0_out}, 32'h01);
      chk("brd.line2", {24'd0, bus.line2_out}, 32'h11);
      chk("brd.line3", {24'd0, bus.line3_out}, 32'h11);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
